alu_exec_seq: RTL and testbench

//   Execute-stage sequencer wrapped around the 8-bit combinational ALU
//   (ops: AND/OR/COMP/RRC/RLC/ADD/SUB/MOVE with cin/cout).
//   - Accepts register-to-register instructions over a valid/ready handshake.
//   - Reads operands from a small register file and drives the ALU inputs.
//   - Captures y/cout, then writes back the result and updates carry/zero flags.
//   - The ALU is instantiated outside this block; its ports connect to alu_*.

---
 rtl/alu_exec_seq.sv | 157 +++++++++++++++
 tb/tb_alu_exec_seq.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_seq.sv
// Execute-stage sequencer for the external 8-bit ALU. It accepts an instruction,
// stages the operands, captures the ALU result and writes it back with the flags.
module alu_exec_seq #(
  parameter int WIDTH = 8,
  parameter int NREGS = 4,
  parameter int RAW   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  // Handshake: a transfer happens on a rising edge where instr_valid and
  // instr_ready are both high. While instr_ready is low, the instr_* inputs
  // are ignored and the source holds them stable.
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [2:0]       instr_op,
  input  logic [RAW-1:0]   instr_rd,
  input  logic [RAW-1:0]   instr_rs,
  input  logic             ld_en,
  input  logic [RAW-1:0]   ld_addr,
  input  logic [WIDTH-1:0] ld_data,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_cin,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_y,
  input  logic             alu_cout,
  output logic             wb_valid,
  output logic [RAW-1:0]   wb_rd,
  output logic [WIDTH-1:0] wb_data,
  output logic             carry_flag,
  output logic             zero_flag,
  input  logic [RAW-1:0]   dbg_rsel,
  output logic [WIDTH-1:0] dbg_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [WIDTH-1:0] regs [NREGS];
  logic [RAW-1:0]   rd_q;
  logic             accept;
  logic             do_wb;
  logic             carry_op;

  assign instr_ready = (state == IDLE) || (state == WB);
  assign accept      = instr_valid && instr_ready;
  assign do_wb       = (state == EXEC);
  assign alu_cin     = carry_flag;
  assign dbg_rdata   = regs[dbg_rsel];

  // Only the rotate and add/subtract ops produce a meaningful carry-out.
  always_comb begin
    carry_op = 1'b0;
    case (alu_op)
      3'b011, 3'b100, 3'b101, 3'b110: carry_op = 1'b1;
      default:                        carry_op = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = EXEC;
        end
      end
      EXEC: begin
        state_next = WB;
      end
      WB: begin
        if (accept) begin
          state_next = EXEC;
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Operand staging; reads see the register file as it was before this edge,
  // so a write landing on the same edge is not forwarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a  <= '0;
      alu_b  <= '0;
      alu_op <= '0;
      rd_q   <= '0;
    end else if (accept) begin
      alu_a  <= regs[instr_rd];
      alu_b  <= regs[instr_rs];
      alu_op <= instr_op;
      rd_q   <= instr_rd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid <= 1'b0;
      wb_rd    <= '0;
      wb_data  <= '0;
    end else begin
      wb_valid <= do_wb;
      if (do_wb) begin
        wb_rd   <= rd_q;
        wb_data <= alu_y;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_flag <= 1'b0;
      zero_flag  <= 1'b0;
    end else if (do_wb) begin
      zero_flag <= (alu_y == '0);
      if (carry_op) begin
        carry_flag <= alu_cout;
      end
    end
  end

  // Writeback has priority over a direct load to the same register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (do_wb && (rd_q == RAW'(i))) begin
          regs[i] <= alu_y;
        end else if (ld_en && (ld_addr == RAW'(i))) begin
          regs[i] <= ld_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_seq.sv
// Directed bench for alu_exec_seq: a small ALU model closes the loop, and a
// writeback monitor checks every wb pulse against an expected-data queue.
module tb_alu_exec_seq;

  localparam int WIDTH = 8;
  localparam int NREGS = 4;
  localparam int RAW   = 2;

  logic             clk;
  logic             rst_n;
  logic             instr_valid;
  logic             instr_ready;
  logic [2:0]       instr_op;
  logic [RAW-1:0]   instr_rd;
  logic [RAW-1:0]   instr_rs;
  logic             ld_en;
  logic [RAW-1:0]   ld_addr;
  logic [WIDTH-1:0] ld_data;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic             alu_cin;
  logic [2:0]       alu_op;
  logic [WIDTH-1:0] alu_y;
  logic             alu_cout;
  logic             wb_valid;
  logic [RAW-1:0]   wb_rd;
  logic [WIDTH-1:0] wb_data;
  logic             carry_flag;
  logic             zero_flag;
  logic [RAW-1:0]   dbg_rsel;
  logic [WIDTH-1:0] dbg_rdata;

  int vec_cnt = 0;
  int err_cnt = 0;
  logic [WIDTH-1:0] exp_q[$];

  alu_exec_seq #(.WIDTH(WIDTH), .NREGS(NREGS), .RAW(RAW)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs(instr_rs),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_op(alu_op),
    .alu_y(alu_y), .alu_cout(alu_cout),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .carry_flag(carry_flag), .zero_flag(zero_flag),
    .dbg_rsel(dbg_rsel), .dbg_rdata(dbg_rdata)
  );

  // Reference ALU: SUB reports borrow on cout.
  logic [WIDTH:0] sum9;
  always_comb begin
    sum9     = '0;
    alu_y    = '0;
    alu_cout = 1'b0;
    case (alu_op)
      3'b000: alu_y = alu_a & alu_b;
      3'b001: alu_y = alu_a | alu_b;
      3'b010: alu_y = ~alu_a;
      3'b011: begin
        alu_y    = {alu_cin, alu_a[WIDTH-1:1]};
        alu_cout = alu_a[0];
      end
      3'b100: begin
        alu_y    = {alu_a[WIDTH-2:0], alu_cin};
        alu_cout = alu_a[WIDTH-1];
      end
      3'b101: begin
        sum9     = {1'b0, alu_a} + {1'b0, alu_b} + {{WIDTH{1'b0}}, alu_cin};
        alu_y    = sum9[WIDTH-1:0];
        alu_cout = sum9[WIDTH];
      end
      3'b110: begin
        sum9     = {1'b0, alu_a} - {1'b0, alu_b} - {{WIDTH{1'b0}}, alu_cin};
        alu_y    = sum9[WIDTH-1:0];
        alu_cout = sum9[WIDTH];
      end
      default: alu_y = alu_b;
    endcase
  end

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: each writeback pulse must match the next expected value.
  always @(negedge clk) begin
    if (wb_valid) begin
      if (exp_q.size() == 0) begin
        check("wb_unexpected", 32'(wb_valid), 32'(0));
      end else begin
        check("wb_data", 32'(wb_data), 32'(exp_q.pop_front()));
      end
    end
  end

  // Drivers
  task automatic load(input logic [RAW-1:0] a, input logic [WIDTH-1:0] d);
    ld_en   = 1'b1;
    ld_addr = a;
    ld_data = d;
    @(posedge clk); #1;
    ld_en   = 1'b0;
  endtask

  task automatic accept(input logic [2:0] op, input logic [RAW-1:0] rd, input logic [RAW-1:0] rs);
    int n;
    instr_valid = 1'b1;
    instr_op    = op;
    instr_rd    = rd;
    instr_rs    = rs;
    n = 0;
    while (!instr_ready && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    if (n == 10) check("accept_timeout", 32'(instr_ready), 32'(1));
    @(posedge clk); #1;
    instr_valid = 1'b0;
  endtask

  // Returns edges from accept (inclusive) to the edge that raised wb_valid.
  task automatic wait_wb(output int edges);
    edges = 1;
    while (edges < 10) begin
      @(posedge clk); #1;
      edges++;
      if (wb_valid) break;
    end
  endtask

  task automatic check_reg(input string tag, input logic [RAW-1:0] a, input logic [WIDTH-1:0] exp);
    dbg_rsel = a;
    #1;
    check(tag, 32'(dbg_rdata), 32'(exp));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int edges;
    rst_n       = 1'b0;
    instr_valid = 1'b0;
    instr_op    = '0;
    instr_rd    = '0;
    instr_rs    = '0;
    ld_en       = 1'b0;
    ld_addr     = '0;
    ld_data     = '0;
    dbg_rsel    = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    check("rst_ready", 32'(instr_ready), 32'(1));
    check("rst_wb_valid", 32'(wb_valid), 32'(0));
    check("rst_c", 32'(carry_flag), 32'(0));
    check("rst_z", 32'(zero_flag), 32'(0));
    check("rst_alu_a", 32'(alu_a), 32'(0));
    for (int i = 0; i < NREGS; i++) check_reg("rst_reg", RAW'(i), 8'h00);

    // ADD with overflow
    load(2'd0, 8'hFF);
    load(2'd1, 8'h01);
    exp_q.push_back(8'h00);
    accept(3'b101, 2'd0, 2'd1);
    check("add_exec_no_wb", 32'(wb_valid), 32'(0));
    wait_wb(edges);
    check("add_latency", 32'(edges), 32'(2));
    check("add_wb_rd", 32'(wb_rd), 32'(0));
    check_reg("add_r0", 2'd0, 8'h00);
    check("add_c", 32'(carry_flag), 32'(1));
    check("add_z", 32'(zero_flag), 32'(1));

    // RLC with carry-in
    exp_q.push_back(8'h03);
    accept(3'b100, 2'd1, 2'd1);
    check("rlc_cin", 32'(alu_cin), 32'(1));
    check("rlc_alu_a", 32'(alu_a), 32'(8'h01));
    check("rlc_alu_op", 32'(alu_op), 32'(3'b100));
    wait_wb(edges);
    check("rlc_latency", 32'(edges), 32'(2));
    check_reg("rlc_r1", 2'd1, 8'h03);
    check("rlc_c", 32'(carry_flag), 32'(0));
    check("rlc_z", 32'(zero_flag), 32'(0));

    // Back-to-back ADD then SUB, second accepted in WB
    load(2'd0, 8'h14);
    load(2'd1, 8'h27);
    exp_q.push_back(8'h3B);
    exp_q.push_back(8'h14);
    accept(3'b101, 2'd0, 2'd1);
    instr_valid = 1'b1;
    instr_op    = 3'b110;
    check("b2b_exec_not_ready", 32'(instr_ready), 32'(0));
    @(posedge clk); #1;
    check("b2b_first_wb", 32'(wb_valid), 32'(1));
    check("b2b_wb_ready", 32'(instr_ready), 32'(1));
    @(posedge clk); #1;
    instr_valid = 1'b0;
    check("b2b_second_accepted", 32'(instr_ready), 32'(0));
    check("b2b_sub_operand", 32'(alu_a), 32'(8'h3B));
    @(posedge clk); #1;
    check("b2b_second_wb_edge4", 32'(wb_valid), 32'(1));
    check_reg("b2b_r0", 2'd0, 8'h14);
    check("b2b_c", 32'(carry_flag), 32'(0));

    // Flag hold through AND and MOVE
    load(2'd0, 8'hFF);
    load(2'd1, 8'h01);
    exp_q.push_back(8'h00);
    accept(3'b101, 2'd0, 2'd1);
    wait_wb(edges);
    check("hold_setup_c", 32'(carry_flag), 32'(1));
    load(2'd0, 8'hA5);
    load(2'd1, 8'h3C);
    check("load_keeps_c", 32'(carry_flag), 32'(1));
    exp_q.push_back(8'h24);
    accept(3'b000, 2'd0, 2'd1);
    wait_wb(edges);
    check_reg("and_r0", 2'd0, 8'h24);
    check("and_c_hold", 32'(carry_flag), 32'(1));
    check("and_z", 32'(zero_flag), 32'(0));
    exp_q.push_back(8'h3C);
    accept(3'b111, 2'd2, 2'd1);
    wait_wb(edges);
    check("move_wb_rd", 32'(wb_rd), 32'(2));
    check_reg("move_r2", 2'd2, 8'h3C);
    check("move_c_hold", 32'(carry_flag), 32'(1));

    // Load collides with writeback to r0: writeback wins
    exp_q.push_back(8'h3C);
    accept(3'b111, 2'd0, 2'd1);
    ld_en   = 1'b1;
    ld_addr = 2'd0;
    ld_data = 8'h77;
    @(posedge clk); #1;
    ld_en = 1'b0;
    check("coll_wb", 32'(wb_valid), 32'(1));
    check_reg("coll_r0", 2'd0, 8'h3C);

    // Reset during EXEC discards the instruction
    accept(3'b101, 2'd0, 2'd1);
    check("mid_in_exec", 32'(instr_ready), 32'(0));
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", 32'(instr_ready), 32'(1));
    @(posedge clk); #1;
    check("mid_rst_no_wb", 32'(wb_valid), 32'(0));
    rst_n = 1'b1;
    check("mid_ready_after", 32'(instr_ready), 32'(1));
    check("mid_c", 32'(carry_flag), 32'(0));
    for (int i = 0; i < NREGS; i++) check_reg("mid_reg", RAW'(i), 8'h00);
    repeat (3) begin
      @(posedge clk); #1;
      check("mid_idle_no_wb", 32'(wb_valid), 32'(0));
    end

    check("exp_q_drained", 32'(exp_q.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
